amp_gain_apply: RTL and testbench

Sample-path gain stage that consumes the one-hot power-of-two multiplier `M` produced by the button-driven gain register and applies it to a signed sample stream. It sits between the sample source and the output DAC/formatter. Processing runs on the shared sample clock-enable `ce`. Gain changes are deferred to an input zero crossing, with a timeout, so that steps do not cause audible clicks. Each result is saturated to the output width.

---
 rtl/amp_gain_apply.sv | 174 +++++++++++++++++
 tb/tb_amp_gain_apply.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/amp_gain_apply.sv
// Gain stage: applies one-hot power-of-two gain M to a signed sample stream and saturates to OW bits.
// Build option AMP_GAIN_ZC_EN defers gain changes to a zero crossing of din, or to a timeout.
module amp_gain_apply #(
  parameter int unsigned DW         = 12,
  parameter int unsigned OW         = 16,
  parameter int unsigned ZC_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic [7:0]    M,
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  output logic [OW-1:0] dout,
  output logic          dout_vld,
  output logic          sat,
  output logic [2:0]    shift,
  output logic          pend,
  output logic          err
);

  localparam int unsigned SW = DW + 7;
  localparam int unsigned CW = (OW > SW) ? OW + 1 : SW + 1;
  localparam int unsigned KW = 8;
  localparam logic signed [CW-1:0] MAX_V = {{(CW - OW + 1){1'b0}}, {(OW - 1){1'b1}}};
  localparam logic signed [CW-1:0] MIN_V = ~MAX_V;

  if (OW < DW || ZC_TIMEOUT < 1 || ZC_TIMEOUT > 255) begin : g_bad_cfg
    $error("amp_gain_apply: invalid parameter set");
  end

  logic                 acc_c;
  logic                 onehot_c;
  logic [2:0]           tgt_c;
  logic [2:0]           shift_q, shift_d;
  logic                 err_q, err_d;
  logic                 s1_vld_q, s2_vld_q, s3_vld_q;
  logic signed [DW-1:0] s1_din_q;
  logic [2:0]           s1_sh_q;
  logic signed [SW-1:0] s2_q, s2_d;
  logic signed [CW-1:0] wide_c;
  logic [OW-1:0]        s3_q, s3_d;
  logic                 s3_clip_q, s3_clip_d;
  logic [OW-1:0]        dout_q;
  logic                 sat_q, dout_vld_q;

`ifdef AMP_GAIN_ZC_EN
  logic [KW-1:0] cnt_q, cnt_d;
  logic          prev_q, prev_d;
  logic          pend_q, pend_d;
  logic          zc_c;
`endif

  assign acc_c = ce & din_vld;

  // One-hot decode; an illegal M keeps the currently applied shift as target
  always_comb begin
    tgt_c    = shift_q;
    onehot_c = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (M == 8'(1 << i)) begin
        tgt_c    = 3'(i);
        onehot_c = 1'b1;
      end
    end
  end

  // Stage 1 gain decision
  always_comb begin
    shift_d = shift_q;
    err_d   = err_q;
`ifdef AMP_GAIN_ZC_EN
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    pend_d  = pend_q;
    zc_c    = (din == '0) || (din[DW-1] != prev_q);
`endif
    if (acc_c) begin
      if (!onehot_c) err_d = 1'b1;
`ifdef AMP_GAIN_ZC_EN
      prev_d = din[DW-1];
      if (tgt_c == shift_q) begin
        cnt_d  = '0;
        pend_d = 1'b0;
      end else if (zc_c || cnt_q == KW'(ZC_TIMEOUT - 1)) begin
        shift_d = tgt_c;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end else begin
        cnt_d  = cnt_q + KW'(1);
        pend_d = 1'b1;
      end
`else
      shift_d = tgt_c;
`endif
    end
  end

  // Stages 2 and 3: widen and shift, then clip to the output range
  always_comb begin
    s2_d   = SW'(s1_din_q) <<< s1_sh_q;
    wide_c = CW'(s2_q);
    s3_d      = wide_c[OW-1:0];
    s3_clip_d = 1'b0;
    if (wide_c > MAX_V) begin
      s3_d      = MAX_V[OW-1:0];
      s3_clip_d = 1'b1;
    end else if (wide_c < MIN_V) begin
      s3_d      = MIN_V[OW-1:0];
      s3_clip_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= 3'd7;
      err_q      <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_din_q   <= '0;
      s1_sh_q    <= '0;
      s2_vld_q   <= 1'b0;
      s2_q       <= '0;
      s3_vld_q   <= 1'b0;
      s3_q       <= '0;
      s3_clip_q  <= 1'b0;
      dout_q     <= '0;
      sat_q      <= 1'b0;
      dout_vld_q <= 1'b0;
    end else begin
      dout_vld_q <= ce & s3_vld_q;
      if (ce) begin
        shift_q   <= shift_d;
        err_q     <= err_d;
        s1_vld_q  <= din_vld;
        s1_din_q  <= din;
        s1_sh_q   <= shift_d;
        s2_vld_q  <= s1_vld_q;
        s2_q      <= s2_d;
        s3_vld_q  <= s2_vld_q;
        s3_q      <= s3_d;
        s3_clip_q <= s3_clip_d;
        if (s3_vld_q) begin
          dout_q <= s3_q;
          sat_q  <= s3_clip_q;
        end
      end
    end
  end

`ifdef AMP_GAIN_ZC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else if (ce) begin
      cnt_q  <= cnt_d;
      prev_q <= prev_d;
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;
`else
  assign pend = 1'b0;
`endif

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign sat      = sat_q;
  assign shift    = shift_q;
  assign err      = err_q;

endmodule

// File: tb/tb_amp_gain_apply.sv
// Self-checking bench for amp_gain_apply: vector table, corner-case sequences and a random run
// compared against a latency-queue reference model. Honours AMP_GAIN_ZC_EN like the design.
module tb_amp_gain_apply;

  localparam int unsigned DW = 12;
  localparam int unsigned OW = 16;
  localparam int unsigned ZC_TIMEOUT = 4;
`ifdef AMP_GAIN_ZC_EN
  localparam bit ZC_EN = 1'b1;
`else
  localparam bit ZC_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ce = 1'b0;
  logic [7:0]    m = 8'h80;
  logic [DW-1:0] din = '0;
  logic          din_vld = 1'b0;
  logic [OW-1:0] dout;
  logic          dout_vld, sat, pend, err;
  logic [2:0]    shift;

  amp_gain_apply #(.DW(DW), .OW(OW), .ZC_TIMEOUT(ZC_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .M(m), .din(din), .din_vld(din_vld),
    .dout(dout), .dout_vld(dout_vld), .sat(sat), .shift(shift), .pend(pend), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: gain rules as plain arithmetic, results queued with their due ce index
  typedef struct { int unsigned due; logic [OW-1:0] val; logic clip; } res_t;
  res_t          rq[$];
  int unsigned   ce_cnt;
  int            m_shift, m_cnt;
  bit            m_pend, m_err, m_prev;
  logic [OW-1:0] e_dout;
  bit            e_sat, e_vld;

  typedef struct { logic [7:0] mm; logic [DW-1:0] d; logic [OW-1:0] q; logic s; } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    rq.delete();
    ce_cnt = 0; m_shift = 7; m_cnt = 0;
    m_pend = 0; m_err = 0; m_prev = 0;
    e_dout = '0; e_sat = 0; e_vld = 0;
  endtask

  task automatic model_edge(input bit c, input bit v, input logic [7:0] mm, input logic [DW-1:0] d);
    int t;
    bit sgn;
    longint p, hi, lo;
    res_t r;
    e_vld = 0;
    if (!c) return;
    ce_cnt++;
    if (rq.size() > 0 && rq[0].due == ce_cnt) begin
      r = rq.pop_front();
      e_dout = r.val; e_sat = r.clip; e_vld = 1;
    end
    if (!v) return;
    sgn = d[DW-1];
    if ($countones(mm) != 1) begin
      t = m_shift; m_err = 1;
    end else begin
      t = $clog2(mm);
    end
    if (t == m_shift) begin
      m_cnt = 0; m_pend = 0;
    end else if (!ZC_EN || d == '0 || sgn != m_prev || m_cnt == int'(ZC_TIMEOUT) - 1) begin
      m_shift = t; m_cnt = 0; m_pend = 0;
    end else begin
      m_cnt++; m_pend = 1;
    end
    m_prev = sgn;
    p  = longint'($signed(d)) * (longint'(1) << m_shift);
    hi = (longint'(1) << (OW - 1)) - 1;
    lo = -(longint'(1) << (OW - 1));
    r.due = ce_cnt + 3;
    r.clip = (p > hi) || (p < lo);
    if (p > hi) p = hi;
    if (p < lo) p = lo;
    r.val = OW'(p);
    rq.push_back(r);
  endtask

  task automatic compare_all();
    check("dout_vld", 32'(dout_vld), 32'(e_vld));
    check("dout", 32'(dout), 32'(e_dout));
    check("sat", 32'(sat), 32'(e_sat));
    check("shift", 32'(shift), 32'(m_shift));
    check("pend", 32'(pend), 32'(m_pend));
    check("err", 32'(err), 32'(m_err));
  endtask

  task automatic step(input bit c, input bit v, input logic [7:0] mm, input logic [DW-1:0] d);
    ce = c; din_vld = v; m = mm; din = d;
    @(posedge clk);
    model_edge(c, v, mm, d);
    #1;
    compare_all();
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, m, '0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0; ce = 1'b0; din_vld = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0]    rm;
    logic [DW-1:0] rd;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    compare_all();
    rst_n = 1'b1;

    // Basic gain/saturation vectors at M=0x80
    tbl[0] = '{8'h80, 12'h001, 16'h0080, 1'b0};
    tbl[1] = '{8'h80, 12'h0FF, 16'h7F80, 1'b0};
    tbl[2] = '{8'h80, 12'h7FF, 16'h7FFF, 1'b1};
    tbl[3] = '{8'h80, 12'h800, 16'h8000, 1'b1};
    tbl[4] = '{8'h80, 12'h000, 16'h0000, 1'b0};
    tbl[5] = '{8'h80, 12'hFFF, 16'hFF80, 1'b0};
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, tbl[i].mm, tbl[i].d);
      step(1'b1, 1'b0, tbl[i].mm, '0);
      step(1'b1, 1'b0, tbl[i].mm, '0);
      step(1'b1, 1'b0, tbl[i].mm, '0);
      check("tbl_dout", 32'(dout), 32'(tbl[i].q));
      check("tbl_sat", 32'(sat), 32'(tbl[i].s));
      check("tbl_vld", 32'(dout_vld), 32'd1);
    end

    // Zero-crossing deferral: +100 stream, M drops to 0x01, then a negative sample
    step(1'b1, 1'b1, 8'h80, 12'd100);
    step(1'b1, 1'b1, 8'h80, 12'd100);
    flush(3);
    step(1'b1, 1'b1, 8'h01, 12'd100);
    check("zc_pend", 32'(pend), 32'(ZC_EN));
    step(1'b1, 1'b1, 8'h01, 12'd100);
    step(1'b1, 1'b1, 8'h01, 12'd100);
    flush(3);
    check("zc_hold_dout", 32'(dout), ZC_EN ? 32'd12800 : 32'd100);
    step(1'b1, 1'b1, 8'h01, 12'hF9C);
    flush(3);
    check("zc_cross_dout", 32'(dout), 32'h0000FF9C);
    check("zc_cross_shift", 32'(shift), 32'd0);
    check("zc_cross_pend", 32'(pend), 32'd0);

    // Timeout: constant +5, M 0x80 -> 0x02
    step(1'b1, 1'b1, 8'h80, 12'd5);
    step(1'b1, 1'b1, 8'h80, 12'd5);
    flush(3);
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 1'b1, 8'h02, 12'd5);
      check("to_pend", 32'(pend), (ZC_EN && k < 4) ? 32'd1 : 32'd0);
    end
    check("to_first_dout", 32'(dout), ZC_EN ? 32'd640 : 32'd10);
    check("to_shift", 32'(shift), 32'd1);
    flush(3);
    check("to_last_dout", 32'(dout), 32'd10);

    // Non-one-hot M: sticky err, shift kept
    step(1'b1, 1'b1, 8'h03, 12'd5);
    check("err_set", 32'(err), 32'd1);
    check("err_shift", 32'(shift), 32'd1);
    step(1'b1, 1'b1, 8'h00, 12'd5);
    step(1'b1, 1'b1, 8'h02, 12'd5);
    check("err_sticky", 32'(err), 32'd1);
    flush(3);
    pulse_reset();
    check("err_cleared", 32'(err), 32'd0);

    // Asynchronous reset with three samples in flight
    step(1'b1, 1'b1, 8'h80, 12'd7);
    step(1'b1, 1'b1, 8'h80, 12'd9);
    step(1'b1, 1'b1, 8'h80, 12'd11);
    #2;
    pulse_reset();
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_shift", 32'(shift), 32'd7);
    flush(6);

    // ce held low: no advance, din_vld ignored
    step(1'b1, 1'b1, 8'h80, 12'd3);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h01, 12'h800);
    check("ce_low_shift", 32'(shift), 32'd7);
    flush(3);
    check("ce_low_dout", 32'(dout), 32'd384);

    // Random traffic against the model
    rm = 8'h80;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 9) == 0) rm = 8'($urandom);
        else rm = 8'(1 << $urandom_range(0, 7));
      end
      case ($urandom_range(0, 4))
        0: rd = '0;
        1: rd = DW'($urandom_range(0, 15));
        2: rd = DW'(-$urandom_range(1, 15));
        default: rd = DW'($urandom);
      endcase
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, rm, rd);
    end
    flush(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
